// File: rtl/tile_job_feeder_pkg.sv
// Shared definitions for the tile job feeder: word-type codes carried on the
// manager fifo port and a helper to classify host field types.
package tile_job_feeder_pkg;

  localparam logic [2:0] WT_ADDR  = 3'd0;
  localparam logic [2:0] WT_ZOOM  = 3'd1;
  localparam logic [2:0] WT_REAL  = 3'd2;
  localparam logic [2:0] WT_IMAG  = 3'd3;
  localparam logic [2:0] WT_START = 3'd4;

  // True for host field types that address slot storage (addr, zoom, limbs).
  function automatic logic is_field_type(input logic [2:0] t);
    return (t <= WT_IMAG);
  endfunction

endpackage

// File: rtl/tile_job_slot.sv
// One job buffer: address, zoom and the real/imag limb arrays. Contents are
// deliberately not reset; a slot is only read after the host committed it.
module tile_job_slot
  import tile_job_feeder_pkg::*;
#(
  parameter int NUM_LIMBS       = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27
)(
  input  logic                       clock,
  input  logic                       wr_en,
  input  logic [2:0]                 wr_type,
  input  logic [LIMB_INDEX_BITS-1:0] wr_limb,
  input  logic [31:0]                wr_data,
  input  logic                       rd_imag,
  input  logic [LIMB_INDEX_BITS-1:0] rd_limb,
  output logic [31:0]                addr,
  output logic [31:0]                zoom,
  output logic [LIMB_SIZE_BITS-1:0]  rd_data
);

  logic [31:0]               addr_r;
  logic [31:0]               zoom_r;
  logic [LIMB_SIZE_BITS-1:0] real_r [NUM_LIMBS];
  logic [LIMB_SIZE_BITS-1:0] imag_r [NUM_LIMBS];

  // Field write port; the caller has already filtered illegal accesses.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      case (wr_type)
        WT_ADDR: addr_r <= wr_data;
        WT_ZOOM: zoom_r <= wr_data;
        WT_REAL: begin
          for (int i = 0; i < NUM_LIMBS; i++) begin
            if (wr_limb == LIMB_INDEX_BITS'(i)) begin
              real_r[i] <= wr_data[LIMB_SIZE_BITS-1:0];
            end
          end
        end
        WT_IMAG: begin
          for (int i = 0; i < NUM_LIMBS; i++) begin
            if (wr_limb == LIMB_INDEX_BITS'(i)) begin
              imag_r[i] <= wr_data[LIMB_SIZE_BITS-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Combinational limb read selected by coordinate and index.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_LIMBS; i++) begin
      if (rd_limb == LIMB_INDEX_BITS'(i)) begin
        rd_data = rd_imag ? imag_r[i] : real_r[i];
      end else begin
        rd_data = rd_data;
      end
    end
  end

  assign addr = addr_r;
  assign zoom = zoom_r;

endmodule

// File: rtl/tile_job_feeder.sv
// Double-buffered job sequencer: the host fills one slot while the other is
// streamed to the solver manager as typed words ending with a start word.
module tile_job_feeder
  import tile_job_feeder_pkg::*;
#(
  parameter int NUM_LIMBS       = 4,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27
)(
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       host_wr_en,
  input  logic [2:0]                 host_wr_type,
  input  logic [LIMB_INDEX_BITS-1:0] host_wr_limb,
  input  logic [31:0]                host_wr_data,
  input  logic                       host_commit,
  input  logic                       host_err_clr,
  output logic                       host_slot_free,
  output logic                       host_error,
  output logic                       fifo_valid,
  output logic [2:0]                 fifo_data_type,
  output logic [31:0]                fifo_data,
  input  logic                       fifo_ready,
  output logic                       busy,
  output logic [15:0]                jobs_issued
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0, ST_ADDR = 3'd1, ST_ZOOM = 3'd2, ST_REAL = 3'd3,
    ST_IMAG  = 3'd4, ST_START = 3'd5, ST_GAP = 3'd6
  } state_t;

  state_t                     state_r, state_s;
  logic [LIMB_INDEX_BITS-1:0] limb_cnt_r, limb_cnt_s;
  logic [1:0]                 full_r, full_s;
  logic                       load_ptr_r, load_ptr_s, issue_ptr_r, issue_ptr_s;
  logic                       fifo_valid_r, fifo_valid_s;
  logic [2:0]                 fifo_type_r, fifo_type_s;
  logic [31:0]                fifo_data_r, fifo_data_s;
  logic                       host_error_r, host_error_s;
  logic [15:0]                jobs_r, jobs_s;
  logic                       gap_s, slot_free_s, legal_s, wr_ok_s, commit_ok_s, err_event_s;
  logic                       xfer_s, limb_last_s, rd_sel_s, rd_imag_s;
  logic [LIMB_INDEX_BITS-1:0] rd_limb_s;
  logic [31:0]                slot_addr_s [2];
  logic [31:0]                slot_zoom_s [2];
  logic [LIMB_SIZE_BITS-1:0]  slot_limb_s [2];
  logic [31:0]                sel_addr_s, sel_zoom_s, sel_limb_s;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    tile_job_slot #(
      .NUM_LIMBS(NUM_LIMBS), .LIMB_INDEX_BITS(LIMB_INDEX_BITS), .LIMB_SIZE_BITS(LIMB_SIZE_BITS)
    ) u_slot (
      .clock(clock), .wr_en(wr_ok_s && (load_ptr_r == 1'(g))), .wr_type(host_wr_type),
      .wr_limb(host_wr_limb), .wr_data(host_wr_data), .rd_imag(rd_imag_s), .rd_limb(rd_limb_s),
      .addr(slot_addr_s[g]), .zoom(slot_zoom_s[g]), .rd_data(slot_limb_s[g])
    );
  end

  // Host access qualification and slot/pointer bookkeeping. A GAP free of the
  // load slot makes it available in the same cycle, so a commit then re-fills it.
  always_comb begin
    gap_s       = (state_r == ST_GAP);
    slot_free_s = ~full_r[load_ptr_r] | (gap_s & (issue_ptr_r == load_ptr_r));
    legal_s     = is_field_type(host_wr_type) &
                  ((host_wr_type < WT_REAL) | (32'(host_wr_limb) < NUM_LIMBS));
    wr_ok_s     = host_wr_en & slot_free_s & legal_s;
    commit_ok_s = host_commit & slot_free_s;
    err_event_s = (host_wr_en & ~wr_ok_s) | (host_commit & ~slot_free_s);
    full_s      = full_r;
    load_ptr_s  = load_ptr_r;
    issue_ptr_s = issue_ptr_r;
    jobs_s      = jobs_r;
    if (gap_s) begin
      full_s[issue_ptr_r] = 1'b0;
      issue_ptr_s         = ~issue_ptr_r;
      jobs_s              = jobs_r + 16'd1;
    end else begin
      issue_ptr_s = issue_ptr_r;
    end
    if (commit_ok_s) begin
      full_s[load_ptr_r] = 1'b1;
      load_ptr_s         = ~load_ptr_r;
    end else begin
      load_ptr_s = load_ptr_r;
    end
    if (err_event_s) begin
      host_error_s = 1'b1;
    end else if (host_err_clr) begin
      host_error_s = 1'b0;
    end else begin
      host_error_s = host_error_r;
    end
  end

  // Read address for the word loaded on the next transfer; in GAP the next
  // job comes from the other slot.
  always_comb begin
    limb_last_s = (limb_cnt_r == LIMB_INDEX_BITS'(NUM_LIMBS - 1));
    rd_sel_s    = gap_s ? ~issue_ptr_r : issue_ptr_r;
    rd_imag_s   = 1'b0;
    rd_limb_s   = '0;
    case (state_r)
      ST_REAL: begin
        rd_imag_s = limb_last_s;
        rd_limb_s = limb_last_s ? '0 : limb_cnt_r + LIMB_INDEX_BITS'(1);
      end
      ST_IMAG: begin
        rd_imag_s = 1'b1;
        rd_limb_s = limb_cnt_r + LIMB_INDEX_BITS'(1);
      end
      default: begin
        rd_imag_s = 1'b0;
        rd_limb_s = '0;
      end
    endcase
    sel_addr_s = slot_addr_s[rd_sel_s];
    sel_zoom_s = slot_zoom_s[rd_sel_s];
    sel_limb_s = 32'(slot_limb_s[rd_sel_s]);
  end

  // Sequencer next state and next registered fifo word; words hold while stalled.
  always_comb begin
    xfer_s       = fifo_valid_r & fifo_ready;
    state_s      = state_r;
    limb_cnt_s   = limb_cnt_r;
    fifo_valid_s = fifo_valid_r;
    fifo_type_s  = fifo_type_r;
    fifo_data_s  = fifo_data_r;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (full_r[rd_sel_s]) begin
          state_s      = ST_ADDR;
          fifo_valid_s = 1'b1;
          fifo_type_s  = WT_ADDR;
          fifo_data_s  = sel_addr_s;
        end else begin
          state_s      = ST_IDLE;
          fifo_valid_s = 1'b0;
        end
      end
      ST_ADDR: begin
        if (xfer_s) begin
          state_s     = ST_ZOOM;
          fifo_type_s = WT_ZOOM;
          fifo_data_s = sel_zoom_s;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_ZOOM: begin
        if (xfer_s) begin
          state_s     = ST_REAL;
          limb_cnt_s  = '0;
          fifo_type_s = WT_REAL;
          fifo_data_s = sel_limb_s;
        end else begin
          state_s = ST_ZOOM;
        end
      end
      ST_REAL: begin
        if (xfer_s && limb_last_s) begin
          state_s     = ST_IMAG;
          limb_cnt_s  = '0;
          fifo_type_s = WT_IMAG;
          fifo_data_s = sel_limb_s;
        end else if (xfer_s) begin
          limb_cnt_s  = limb_cnt_r + LIMB_INDEX_BITS'(1);
          fifo_data_s = sel_limb_s;
        end else begin
          state_s = ST_REAL;
        end
      end
      ST_IMAG: begin
        if (xfer_s && limb_last_s) begin
          state_s     = ST_START;
          fifo_type_s = WT_START;
          fifo_data_s = 32'd0;
        end else if (xfer_s) begin
          limb_cnt_s  = limb_cnt_r + LIMB_INDEX_BITS'(1);
          fifo_data_s = sel_limb_s;
        end else begin
          state_s = ST_IMAG;
        end
      end
      ST_START: begin
        if (xfer_s) begin
          state_s      = ST_GAP;
          fifo_valid_s = 1'b0;
        end else begin
          state_s = ST_START;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        fifo_valid_s = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      limb_cnt_r   <= '0;
      full_r       <= 2'b00;
      load_ptr_r   <= 1'b0;
      issue_ptr_r  <= 1'b0;
      fifo_valid_r <= 1'b0;
      fifo_type_r  <= 3'd0;
      fifo_data_r  <= 32'd0;
      host_error_r <= 1'b0;
      jobs_r       <= 16'd0;
    end else begin
      state_r      <= state_s;
      limb_cnt_r   <= limb_cnt_s;
      full_r       <= full_s;
      load_ptr_r   <= load_ptr_s;
      issue_ptr_r  <= issue_ptr_s;
      fifo_valid_r <= fifo_valid_s;
      fifo_type_r  <= fifo_type_s;
      fifo_data_r  <= fifo_data_s;
      host_error_r <= host_error_s;
      jobs_r       <= jobs_s;
    end
  end

  assign host_slot_free = slot_free_s;
  assign host_error     = host_error_r;
  assign fifo_valid     = fifo_valid_r;
  assign fifo_data_type = fifo_type_r;
  assign fifo_data      = fifo_data_r;
  assign busy           = (state_r != ST_IDLE) | (|full_r);
  assign jobs_issued    = jobs_r;

endmodule

// File: tb/tb_tile_job_feeder.sv
// Directed bench for tile_job_feeder: job streaming, stalls, slot exhaustion,
// illegal accesses, commit during GAP and mid-job reset.
module tb_tile_job_feeder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [2:0]  host_wr_type = 3'd0;
  logic [5:0]  host_wr_limb = 6'd0;
  logic [31:0] host_wr_data = 32'd0;
  logic        host_commit = 1'b0;
  logic        host_err_clr = 1'b0;
  logic        host_slot_free, host_error, fifo_valid, busy;
  logic [2:0]  fifo_data_type;
  logic [31:0] fifo_data;
  logic        fifo_ready = 1'b0;
  logic [15:0] jobs_issued;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;

  tile_job_feeder #(.NUM_LIMBS(4), .LIMB_INDEX_BITS(6), .LIMB_SIZE_BITS(27)) dut (
    .clock(clock), .reset_n(reset_n), .host_wr_en(host_wr_en), .host_wr_type(host_wr_type),
    .host_wr_limb(host_wr_limb), .host_wr_data(host_wr_data), .host_commit(host_commit),
    .host_err_clr(host_err_clr), .host_slot_free(host_slot_free), .host_error(host_error),
    .fifo_valid(fifo_valid), .fifo_data_type(fifo_data_type), .fifo_data(fifo_data),
    .fifo_ready(fifo_ready), .busy(busy), .jobs_issued(jobs_issued)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input logic [2:0] t, input logic [5:0] l, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_type = t; host_wr_limb = l; host_wr_data = d;
    step();
    host_wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    host_commit = 1'b1;
    step();
    host_commit = 1'b0;
  endtask

  task automatic clr_pulse();
    host_err_clr = 1'b1;
    step();
    host_err_clr = 1'b0;
  endtask

  task automatic load_fields(input logic [31:0] a, input logic [31:0] z,
                             input logic [31:0] rb, input logic [31:0] ib);
    host_write(3'd0, 6'd0, a);
    host_write(3'd1, 6'd0, z);
    for (int i = 0; i < 4; i++) host_write(3'd2, 6'(i), rb + 32'(i));
    for (int i = 0; i < 4; i++) host_write(3'd3, 6'(i), ib + 32'(i));
  endtask

  // Waits (bounded) for a transfer with ready held as driven, checks the word.
  task automatic get_word(input string tag, input logic [2:0] et, input logic [31:0] ed,
                          input bit chk_data);
    int n;
    n = 0;
    while (!(fifo_valid === 1'b1 && fifo_ready === 1'b1) && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("%s_timeout", tag), 32'(n < 40), 32'd1);
    chk($sformatf("%s_type", tag), 32'(fifo_data_type), 32'(et));
    if (chk_data) chk($sformatf("%s_data", tag), fifo_data, ed);
    step();
  endtask

  // Randomly stalls; every sample with valid high must show the expected word.
  task automatic get_word_r(input string tag, input logic [2:0] et, input logic [31:0] ed);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      fifo_ready = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
      if (fifo_valid === 1'b1) begin
        chk($sformatf("%s_type", tag), 32'(fifo_data_type), 32'(et));
        chk($sformatf("%s_data", tag), fifo_data, ed);
        done = (fifo_ready === 1'b1);
      end
      step();
      n++;
    end
    chk($sformatf("%s_timeout", tag), 32'(done), 32'd1);
  endtask

  task automatic stream_job(input string tag, input logic [31:0] a, input logic [31:0] z,
                            input logic [31:0] rb, input logic [31:0] ib);
    get_word({tag, "_addr"}, 3'd0, a, 1'b1);
    get_word({tag, "_zoom"}, 3'd1, z, 1'b1);
    for (int i = 0; i < 4; i++) get_word($sformatf("%s_re%0d", tag, i), 3'd2, rb + 32'(i), 1'b1);
    for (int i = 0; i < 4; i++) get_word($sformatf("%s_im%0d", tag, i), 3'd3, ib + 32'(i), 1'b1);
    get_word({tag, "_start"}, 3'd4, 32'd0, 1'b0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(fifo_valid), 32'd0);
    chk("rst_type", 32'(fifo_data_type), 32'd0);
    chk("rst_data", fifo_data, 32'd0);
    chk("rst_free", 32'(host_slot_free), 32'd1);
    chk("rst_err", 32'(host_error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_jobs", 32'(jobs_issued), 32'd0);
    reset_n = 1'b1;
    step();

    // Job A, ready high: addr word valid one cycle after the commit edge
    fifo_ready = 1'b1;
    load_fields(32'h1000, 32'd5, 32'h11, 32'h21);
    commit_pulse();
    chk("a_idle_valid", 32'(fifo_valid), 32'd0);
    chk("a_busy", 32'(busy), 32'd1);
    step();
    chk("a_first_valid", 32'(fifo_valid), 32'd1);
    stream_job("a", 32'h1000, 32'd5, 32'h11, 32'h21);
    chk("a_gap_valid", 32'(fifo_valid), 32'd0);
    step();
    chk("a_jobs", 32'(jobs_issued), 32'd1);
    chk("a_post_valid", 32'(fifo_valid), 32'd0);
    chk("a_post_busy", 32'(busy), 32'd0);

    // Job B with random stalls
    load_fields(32'h2000, 32'd7, 32'h31, 32'h41);
    commit_pulse();
    get_word_r("b_addr", 3'd0, 32'h2000);
    get_word_r("b_zoom", 3'd1, 32'd7);
    for (int i = 0; i < 4; i++) get_word_r($sformatf("b_re%0d", i), 3'd2, 32'h31 + 32'(i));
    for (int i = 0; i < 4; i++) get_word_r($sformatf("b_im%0d", i), 3'd3, 32'h41 + 32'(i));
    get_word_r("b_start", 3'd4, 32'd0);
    chk("b_gap_valid", 32'(fifo_valid), 32'd0);
    fifo_ready = 1'b1;
    step();
    chk("b_jobs", 32'(jobs_issued), 32'd2);

    // Two jobs committed while stalled, third access dropped
    fifo_ready = 1'b0;
    load_fields(32'h3000, 32'd9, 32'h51, 32'h61);
    commit_pulse();
    load_fields(32'h4000, 32'd11, 32'h71, 32'h81);
    commit_pulse();
    chk("full_free", 32'(host_slot_free), 32'd0);
    chk("full_err0", 32'(host_error), 32'd0);
    host_write(3'd0, 6'd0, 32'hDEAD);
    chk("drop_wr_err", 32'(host_error), 32'd1);
    clr_pulse();
    chk("clr_err", 32'(host_error), 32'd0);
    commit_pulse();
    chk("drop_commit_err", 32'(host_error), 32'd1);
    clr_pulse();
    t0 = cyc;
    fifo_ready = 1'b1;
    stream_job("c", 32'h3000, 32'd9, 32'h51, 32'h61);
    chk("c_gap_valid", 32'(fifo_valid), 32'd0);
    step();
    chk("d_spacing", 32'(cyc - t0), 32'd12);
    chk("d_valid", 32'(fifo_valid), 32'd1);
    stream_job("d", 32'h4000, 32'd11, 32'h71, 32'h81);
    step();
    chk("d_jobs", 32'(jobs_issued), 32'd4);
    chk("d_busy", 32'(busy), 32'd0);
    chk("d_valid_end", 32'(fifo_valid), 32'd0);

    // Illegal accesses
    host_write(3'd2, 6'd4, 32'h99);
    chk("limb4_err", 32'(host_error), 32'd1);
    chk("limb4_free", 32'(host_slot_free), 32'd1);
    clr_pulse();
    chk("limb4_clr", 32'(host_error), 32'd0);
    host_write(3'd5, 6'd0, 32'h99);
    chk("type5_err", 32'(host_error), 32'd1);
    chk("type5_busy", 32'(busy), 32'd0);
    host_err_clr = 1'b1;
    host_write(3'd6, 6'd0, 32'h99);
    host_err_clr = 1'b0;
    chk("err_wins_clr", 32'(host_error), 32'd1);
    clr_pulse();
    chk("err_clr2", 32'(host_error), 32'd0);

    // Commit in the GAP cycle of the previous job
    fifo_ready = 1'b0;
    load_fields(32'h5000, 32'd13, 32'h91, 32'hA1);
    commit_pulse();
    load_fields(32'h6000, 32'd15, 32'hB1, 32'hC1);
    fifo_ready = 1'b1;
    stream_job("e", 32'h5000, 32'd13, 32'h91, 32'hA1);
    chk("e_gap_valid", 32'(fifo_valid), 32'd0);
    host_commit = 1'b1;
    step();
    host_commit = 1'b0;
    chk("e_jobs", 32'(jobs_issued), 32'd5);
    chk("e_idle_valid", 32'(fifo_valid), 32'd0);
    step();
    chk("f_valid", 32'(fifo_valid), 32'd1);
    get_word("f_addr", 3'd0, 32'h6000, 1'b1);
    get_word("f_zoom", 3'd1, 32'd15, 1'b1);
    get_word("f_re0", 3'd2, 32'hB1, 1'b1);

    // Reset mid-REAL
    chk("f_mid_type", 32'(fifo_data_type), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(fifo_valid), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_jobs", 32'(jobs_issued), 32'd0);
    chk("post_rst_free", 32'(host_slot_free), 32'd1);
    chk("post_rst_valid", 32'(fifo_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
